// File: rtl/result_checker_param.sv
// result_checker_param: bus-monitoring self-check with loadable answers, timeout and progress count.
// Optional FIRST_FAIL_EN adds capture of the first mismatching index and data.
module result_checker_param #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int CHECK_NUM = 3,
  parameter int IDX_W = 2,
  parameter logic [ADDR_W-1:0] TEST_PORT = 'hFF,
  parameter logic [DATA_W-1:0] BEGIN_SYM = 'h168,
  parameter int ERR_W = 8,
  parameter int DUR_W = 16,
  parameter logic [DUR_W-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              wen,
  input  logic              ans_we,
  input  logic [IDX_W-1:0]  ans_idx,
  input  logic [DATA_W-1:0] ans_data,
  output logic [ERR_W-1:0]  error_num,
  output logic [DUR_W-1:0]  duration,
  output logic [IDX_W-1:0]  checked_cnt,
  output logic              finish,
  output logic              timeout
`ifdef FIRST_FAIL_EN
  ,
  output logic              first_fail_vld,
  output logic [IDX_W-1:0]  first_fail_idx,
  output logic [DATA_W-1:0] first_fail_data
`endif
);
  typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(CHECK_NUM);
  state_t state_q, state_d;
  logic wen_q;
  logic [ERR_W-1:0] err_q, err_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic to_q, to_d;
  logic [DATA_W-1:0] ans_q [2**IDX_W];
  logic acc, start, cmp, miss;
`ifdef FIRST_FAIL_EN
  logic ffv_q, ffv_d;
  logic [IDX_W-1:0] ffi_q, ffi_d;
  logic [DATA_W-1:0] ffd_q, ffd_d;
  assign first_fail_vld = ffv_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_data = ffd_q;
`endif
  // Rising edge of wen only, so a write held across a stall counts once
  assign acc = wen & ~wen_q & (addr == TEST_PORT);
  assign start = acc & (state_q == IDLE) & (data == BEGIN_SYM);
  assign cmp = acc & (state_q == CHECK) & (cnt_q != LAST);
  assign miss = cmp & (data != ans_q[cnt_q]);
  assign error_num = err_q;
  assign duration = dur_q;
  assign checked_cnt = cnt_q;
  assign finish = state_q == REPORT;
  assign timeout = to_q;
  always_comb begin
    state_d = state_q;
    err_d = start ? '0 : miss ? (&err_q ? err_q : err_q + 1'b1) : err_q;
    cnt_d = start ? '0 : cmp ? cnt_q + 1'b1 : cnt_q;
    dur_d = start ? '0 : dur_q;
    to_d = to_q;
    if (start) state_d = CHECK;
    if (state_q == CHECK) begin
      if (cnt_q == LAST) state_d = REPORT;
      else if (dur_q == TIMEOUT - 1'b1) begin
        state_d = REPORT;
        to_d = 1'b1;
      end else dur_d = dur_q + 1'b1;
    end
  end
`ifdef FIRST_FAIL_EN
  always_comb begin
    ffv_d = start ? 1'b0 : (ffv_q | miss);
    ffi_d = start ? '0 : (miss & ~ffv_q) ? cnt_q : ffi_q;
    ffd_d = start ? '0 : (miss & ~ffv_q) ? data : ffd_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ffv_q <= 1'b0;
      ffi_q <= '0;
      ffd_q <= '0;
    end else begin
      ffv_q <= ffv_d;
      ffi_q <= ffi_d;
      ffd_q <= ffd_d;
    end
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      wen_q <= 1'b0;
      err_q <= '1;
      dur_q <= '0;
      cnt_q <= '0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wen_q <= wen;
      err_q <= err_d;
      dur_q <= dur_d;
      cnt_q <= cnt_d;
      to_q <= to_d;
    end
  // Answer table survives reset so a rerun needs no reload
  always_ff @(posedge clk)
    if (ans_we && ans_idx < LAST) ans_q[ans_idx] <= ans_data;
endmodule

// File: tb/tb_result_checker_param.sv
// tb_result_checker_param: directed vectors with hand-computed expectations for result_checker_param.
module tb_result_checker_param;
  logic clk = 0, rst = 1;
  logic [29:0] addr = '0;
  logic [31:0] data = '0;
  logic wen = 0, ans_we = 0;
  logic [1:0] ans_idx = '0;
  logic [31:0] ans_data = '0;
  logic [7:0] error_num;
  logic [15:0] duration;
  logic [1:0] checked_cnt;
  logic finish, timeout;
`ifdef FIRST_FAIL_EN
  logic first_fail_vld;
  logic [1:0] first_fail_idx;
  logic [31:0] first_fail_data;
`endif
  int errs = 0, checks = 0;

  result_checker_param #(.TIMEOUT(16'd20)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
    .ans_we(ans_we), .ans_idx(ans_idx), .ans_data(ans_data),
    .error_num(error_num), .duration(duration), .checked_cnt(checked_cnt),
    .finish(finish), .timeout(timeout)
`ifdef FIRST_FAIL_EN
    , .first_fail_vld(first_fail_vld), .first_fail_idx(first_fail_idx),
    .first_fail_data(first_fail_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d, input int n = 1);
    @(negedge clk);
    addr = a;
    data = d;
    wen = 1;
    repeat (n) @(negedge clk);
    wen = 0;
  endtask

  task automatic ld(input logic [1:0] i, input logic [31:0] v);
    @(negedge clk);
    ans_we = 1;
    ans_idx = i;
    ans_data = v;
    @(negedge clk);
    ans_we = 0;
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic wait_fin(input string tag);
    for (int k = 0; k < 100 && !finish; k++) @(negedge clk);
    check(tag, finish, 1);
  endtask

  task automatic pass(input logic [31:0] d1);
    wr('hFF, 'h168);
    wr('hFF, 40320);
    wr('hFF, d1);
    wr('hFF, 'hD5D);
  endtask

  initial begin
    do_rst();
    check("rst_err", error_num, 'hFF);
    check("rst_dur", duration, 0);
    check("rst_cnt", checked_cnt, 0);
    check("rst_fin", finish, 0);
    check("rst_to", timeout, 0);
    // idle noise: wrong address with begin symbol, right address with other data
    wr('hFE, 'h168);
    wr('hFF, 5);
    repeat (3) @(negedge clk);
    check("idle_err", error_num, 'hFF);
    check("idle_fin", finish, 0);
    check("idle_dur", duration, 0);
    // full pass, all correct
    ld(0, 40320);
    ld(1, 1);
    ld(2, 'hD5D);
    ld(3, 'h1234);
    pass(1);
    wait_fin("s1_fin");
    check("s1_err", error_num, 0);
    check("s1_to", timeout, 0);
    check("s1_cnt", checked_cnt, 3);
    check("s1_dur", duration, 6);
    wr('hFF, 99);
    repeat (3) @(negedge clk);
    check("s1_frz_err", error_num, 0);
    check("s1_frz_dur", duration, 6);
    // one mismatch at index 1
    do_rst();
    pass(2);
    wait_fin("s2_fin");
    check("s2_err", error_num, 1);
    check("s2_cnt", checked_cnt, 3);
`ifdef FIRST_FAIL_EN
    check("s2_ffv", first_fail_vld, 1);
    check("s2_ffi", first_fail_idx, 1);
    check("s2_ffd", first_fail_data, 2);
`endif
    // stalled write held 5 cycles counts once
    do_rst();
    wr('hFF, 'h168);
    wr('hFF, 40320, 5);
    @(negedge clk);
    check("s3_cnt", checked_cnt, 1);
    check("s3_err", error_num, 0);
    check("s3_fin", finish, 0);
    // begin then silence: timeout
    do_rst();
    wr('hFF, 'h168);
    wait_fin("s4_fin");
    check("s4_to", timeout, 1);
    check("s4_dur", duration, 19);
    check("s4_cnt", checked_cnt, 0);
    check("s4_err", error_num, 0);
    // reset mid-check, then a full pass on retained answers
    do_rst();
    wr('hFF, 'h168);
    wr('hFF, 40320);
    wr('hFF, 1);
    @(negedge clk);
    check("s6_mid_cnt", checked_cnt, 2);
    do_rst();
    check("s6_rst_err", error_num, 'hFF);
    check("s6_rst_cnt", checked_cnt, 0);
    pass(1);
    wait_fin("s6_fin");
    check("s6_err", error_num, 0);
    check("s6_cnt", checked_cnt, 3);
    check("s6_to", timeout, 0);
    // load and compare of entry 0 in the same cycle: compare sees old value
    do_rst();
    wr('hFF, 'h168);
    @(negedge clk);
    addr = 'hFF;
    data = 40320;
    wen = 1;
    ans_we = 1;
    ans_idx = 0;
    ans_data = 7;
    @(negedge clk);
    wen = 0;
    ans_we = 0;
    @(negedge clk);
    check("ld_old_err", error_num, 0);
    check("ld_old_cnt", checked_cnt, 1);
    // the new value is in effect on the next pass
    do_rst();
    pass(1);
    wait_fin("ld_new_fin");
    check("ld_new_err", error_num, 1);
`ifdef FIRST_FAIL_EN
    check("ld_new_ffi", first_fail_idx, 0);
    check("ld_new_ffd", first_fail_data, 40320);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
